serial_sub_nor: RTL and testbench

//  Bit-serial unsigned subtractor: the inverse operation to the NOR-gate full-adder datapath.

---
 rtl/serial_sub_pkg.sv | 11 +
 rtl/fs_nor_gate.sv | 32 +++
 rtl/serial_sub_nor.sv | 90 +++++++++
 tb/tb_serial_sub_nor.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial NOR subtractor: FSM encodings and
// the counter-width helper.
package serial_sub_pkg;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;

  function automatic int CNT_W(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/fs_nor_gate.sv
// One-bit full subtractor (a - b - bin) built only from 2-input NOR gates.
module fs_nor_gate (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic n_ab, na_b, a_nb, xn_ab, x_ab;
  logic n_xc, nx_c, x_nc, xn_d;
  logic nbin, t_eq, n_or;

  // a^b: n_ab=~(a|b), na_b=~a&b, a_nb=a&~b, xn_ab=~(a^b)
  nor g0 (n_ab,  a,    b);
  nor g1 (na_b,  a,    n_ab);
  nor g2 (a_nb,  b,    n_ab);
  nor g3 (xn_ab, na_b, a_nb);
  nor g4 (x_ab,  xn_ab, xn_ab);

  // d = x_ab ^ bin, same four-gate xnor followed by an inverter
  nor g5 (n_xc,  x_ab, bin);
  nor g6 (nx_c,  x_ab, n_xc);
  nor g7 (x_nc,  bin,  n_xc);
  nor g8 (xn_d,  nx_c, x_nc);
  nor g9 (d,     xn_d, xn_d);

  // bout = (~a&b) | (~(a^b)&bin); ~(a^b)&bin == ~(x_ab | ~bin)
  nor g10 (nbin, bin,  bin);
  nor g11 (t_eq, x_ab, nbin);
  nor g12 (n_or, na_b, t_eq);
  nor g13 (bout, n_or, n_or);
endmodule

// File: rtl/serial_sub_nor.sv
// Bit-serial unsigned subtractor: a-b computed LSB-first, one bit per clock,
// through a single NOR-only full-subtractor cell, valid/ready on both sides.
module serial_sub_nor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);
  localparam int            CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state, nstate;
  logic [WIDTH-1:0] sa, sb, acc, acc_nxt;
  logic             bflop, d, bo;
  logic [CW-1:0]    cnt;

  fs_nor_gate u_fs (
    .a    (sa[0]),
    .b    (sb[0]),
    .bin  (bflop),
    .d    (d),
    .bout (bo)
  );

  // new bit enters at the MSB; after WIDTH shifts bit 0 of the result is at bit 0
  assign acc_nxt = WIDTH'({d, acc} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start_valid)  nstate = RUN;
      RUN:     if (cnt == LAST)  nstate = DONE;
      DONE:    if (done_ready)   nstate = IDLE;
      default:                   nstate = IDLE;
    endcase
  end

  // outputs decode state only, so no input reaches an output combinationally
  always_comb begin
    start_ready = (state == IDLE);
    done_valid  = (state == DONE);
    busy        = (state == RUN) || (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa         <= '0;
      sb         <= '0;
      acc        <= '0;
      bflop      <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else if (state == IDLE) begin
      if (start_valid) begin
        sa    <= a;
        sb    <= b;
        bflop <= 1'b0;
        cnt   <= '0;
      end
    end else if (state == RUN) begin
      sa    <= sa >> 1;
      sb    <= sb >> 1;
      acc   <= acc_nxt;
      bflop <= bo;
      if (cnt == LAST) begin
        diff       <= acc_nxt;
        borrow_out <= bo;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_serial_sub_nor.sv
// Scoreboard bench: stimulus pushes expected results, monitors pop and compare
// whenever a DUT presents done_valid.
module tb_serial_sub_nor;
  typedef struct {
    logic [31:0] d;
    logic        b;
    int          acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_pass = 0, n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH=8 instance
  logic       sv8, sr8, dv8, dr8, bo8, busy8;
  logic [7:0] a8, b8, diff8;
  exp_t       q8[$];
  logic       dv8_prev = 1'b0;

  serial_sub_nor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .done_valid(dv8), .done_ready(dr8),
    .diff(diff8), .borrow_out(bo8), .busy(busy8)
  );

  // WIDTH=4 instance
  logic       sv4, sr4, dv4, dr4, bo4, busy4;
  logic [3:0] a4, b4, diff4;
  exp_t       q4[$];
  int         last_done4 = -1;

  serial_sub_nor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
    .a(a4), .b(b4), .done_valid(dv4), .done_ready(dr4),
    .diff(diff4), .borrow_out(bo4), .busy(busy4)
  );

  // standalone cell
  logic fa, fb, fbin, fd, fbout;
  fs_nor_gate u_fs (.a(fa), .b(fb), .bin(fbin), .d(fd), .bout(fbout));

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (dv8) begin
        if (q8.size() == 0) check("unexpected_done8", {31'b0, dv8}, 32'd0);
        else begin
          if (!dv8_prev) check("latency8", cyc - q8[0].acc_cyc, 32'd8);
          check("diff8", {24'b0, diff8}, q8[0].d);
          check("borrow8", {31'b0, bo8}, {31'b0, q8[0].b});
          if (dr8) void'(q8.pop_front());
        end
      end
      if (dv4) begin
        if (q4.size() == 0) check("unexpected_done4", {31'b0, dv4}, 32'd0);
        else begin
          check("diff4", {28'b0, diff4}, q4[0].d);
          check("borrow4", {31'b0, bo4}, {31'b0, q4[0].b});
          if (last_done4 >= 0) check("spacing4", cyc - last_done4, 32'd6);
          last_done4 <= cyc;
          if (dr4) void'(q4.pop_front());
        end
      end
    end
    dv8_prev <= dv8;
  end

  task automatic push8(input logic [7:0] ed, input logic eb);
    exp_t e;
    e.d = {24'b0, ed}; e.b = eb; e.acc_cyc = cyc;
    q8.push_back(e);
  endtask

  // present operands, wait for the accept edge (bounded), push expectation
  task automatic start8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic eb);
    logic rdy;
    rdy = 1'b0;
    sv8 = 1'b1; a8 = a; b8 = b;
    for (int t = 0; t < 40 && !rdy; t++) begin
      @(negedge clk); rdy = sr8;
      @(posedge clk); #1;
    end
    sv8 = 1'b0;
    if (!rdy) check("accept_timeout8", 32'd0, 32'd1);
    else push8(ed, eb);
  endtask

  task automatic drain8();
    for (int t = 0; t < 40 && q8.size() != 0; t++) @(posedge clk);
    #1;
    check("drain8", q8.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sr8"},    {31'b0, sr8},   32'd1);
    check({tag, "_dv8"},    {31'b0, dv8},   32'd0);
    check({tag, "_busy8"},  {31'b0, busy8}, 32'd0);
    check({tag, "_diff8"},  {24'b0, diff8}, 32'd0);
    check({tag, "_bo8"},    {31'b0, bo8},   32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    sv8 = 0; dr8 = 1; a8 = 0; b8 = 0;
    sv4 = 0; dr4 = 1; a4 = 0; b4 = 0;
    fa = 0; fb = 0; fbin = 0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_sr4", {31'b0, sr4}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;

    // basic ops
    start8(8'h5A, 8'h3C, 8'h1E, 1'b0); drain8();
    start8(8'h00, 8'h01, 8'hFF, 1'b1); drain8();
    start8(8'hA5, 8'hA5, 8'h00, 1'b0); drain8();

    // held result, ignored start pulses in RUN and DONE
    dr8 = 1'b0;
    start8(8'h3C, 8'h5A, 8'hE2, 1'b1);
    @(posedge clk); #1;
    sv8 = 1'b1; a8 = 8'hFF; b8 = 8'h00;
    @(negedge clk); check("start_ready_run", {31'b0, sr8}, 32'd0);
    @(posedge clk); #1 sv8 = 1'b0;
    for (int t = 0; t < 20 && !dv8; t++) begin @(posedge clk); #1; end
    check("reach_done", {31'b0, dv8}, 32'd1);
    sv8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
    repeat (5) begin
      @(negedge clk); check("start_ready_done", {31'b0, sr8}, 32'd0);
      @(posedge clk); #1;
    end
    sv8 = 1'b0;
    dr8 = 1'b1;
    drain8();
    repeat (12) @(posedge clk);
    #1 check("idle_after_hold", {31'b0, busy8}, 32'd0);

    // reset at RUN cycle 4
    start8(8'h12, 8'h34, 8'hDE, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    q8.delete();
    #1 check_reset_outputs("midrun");
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1 check("no_done_after_abort", {31'b0, busy8}, 32'd0);
    start8(8'hFF, 8'h80, 8'h7F, 1'b0); drain8();

    // WIDTH=4 exhaustive, start_valid and done_ready held high
    sv4 = 1'b1; dr4 = 1'b1;
    for (int i = 0; i < 256; i++) begin
      logic rdy;
      logic [3:0] ed;
      exp_t e;
      a4 = i[7:4]; b4 = i[3:0];
      rdy = 1'b0;
      for (int t = 0; t < 20 && !rdy; t++) begin
        @(negedge clk); rdy = sr4;
        @(posedge clk); #1;
      end
      if (!rdy) check("accept_timeout4", 32'd0, 32'd1);
      else begin
        ed = a4 - b4;
        e.d = {28'b0, ed}; e.b = (a4 < b4); e.acc_cyc = cyc;
        q4.push_back(e);
      end
    end
    sv4 = 1'b0;
    for (int t = 0; t < 40 && q4.size() != 0; t++) @(posedge clk);
    #1 check("drain4", q4.size(), 32'd0);

    // NOR cell truth table against integer a-b-bin
    for (int i = 0; i < 8; i++) begin
      int r;
      fa = i[2]; fb = i[1]; fbin = i[0];
      #1;
      r = int'(fa) - int'(fb) - int'(fbin);
      check("fs_d",    {31'b0, fd},    {31'b0, r[0]});
      check("fs_bout", {31'b0, fbout}, {31'b0, (r < 0)});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
